// File: rtl/ring_delay_meter_if.sv
// ---------------------------------------------------------------------------
// ring_delay_meter_if
//   Control/result bundle between the logic-analyser registers (master) and
//   ring_delay_meter (slave).
//   start          : one-cycle measurement request
//   window_cycles  : measurement window length in clock cycles
//   settle_cycles  : ring warm-up time before the window opens
//   result_ack     : consumer acknowledge of a presented result
//   busy           : meter is not idle
//   result         : ticks counted during the window (mod 2^CW)
//   result_valid   : result is presented and held stable
// ---------------------------------------------------------------------------
interface ring_delay_meter_if #(
    parameter int CW = 16,
    parameter int WW = 16,
    parameter int SW = 8
);
    logic          start;
    logic [WW-1:0] window_cycles;
    logic [SW-1:0] settle_cycles;
    logic          result_ack;
    logic          busy;
    logic [CW-1:0] result;
    logic          result_valid;

    modport master (
        output start, window_cycles, settle_cycles, result_ack,
        input  busy, result, result_valid
    );

    modport slave (
        input  start, window_cycles, settle_cycles, result_ack,
        output busy, result, result_valid
    );
endinterface

// File: rtl/ring_delay_meter.sv
// ---------------------------------------------------------------------------
// ring_delay_meter
//   Enables the adder ring oscillator, synchronises its Gray-coded tick
//   counter into wb_clk_i and counts ticks over a programmable window.
//   The tick count is returned through a valid/ack handshake.
// Ports:
//   wb_clk_i        : system clock, rising edge
//   wb_rst_i        : synchronous active-high reset
//   lab             : control/result bundle (slave side)
//   ring_count_gray : Gray-coded ring tick counter, asynchronous domain
//   ring_en         : ring oscillator enable
// ---------------------------------------------------------------------------
module ring_delay_meter #(
    parameter int CW = 16,
    parameter int WW = 16,
    parameter int SW = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    ring_delay_meter_if.slave   lab,
    input  logic [CW-1:0]       ring_count_gray,
    output logic                ring_en
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] SETTLE  = 2'd1;
    localparam logic [1:0] MEASURE = 2'd2;
    localparam logic [1:0] DONE    = 2'd3;

    // Shared phase counter must hold both settle+1 and window-1.
    localparam int CNTW = (WW > SW + 2) ? WW : SW + 2;

    logic [1:0]      state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic [WW-1:0]   win_q, win_d;
    logic [SW-1:0]   set_q, set_d;
    logic [CW-1:0]   start_val_q, start_val_d;
    logic [CW-1:0]   result_q, result_d;
    logic            valid_q, valid_d;
    logic            ring_en_q, ring_en_d;
    logic [CW-1:0]   sync1_q, sync2_q;
    logic [CW-1:0]   sync_bin;
    logic [CNTW-1:0] settle_last, win_last;

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        sync_bin = '0;
        for (int i = 0; i < CW; i++) begin
            sync_bin[i] = ^(sync2_q >> i);
        end
    end

    // SETTLE lasts settle+2 cycles so the window opens on a fully synchronised value.
    assign settle_last = CNTW'(set_q) + CNTW'(1);
    assign win_last    = CNTW'(win_q) - CNTW'(1);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        win_d       = win_q;
        set_d       = set_q;
        start_val_d = start_val_q;
        result_d    = result_q;
        valid_d     = valid_q;
        case (state_q)
            IDLE: begin
                if (lab.start) begin
                    // A zero window still measures for one cycle.
                    win_d   = (lab.window_cycles == '0) ? WW'(1) : lab.window_cycles;
                    set_d   = lab.settle_cycles;
                    cnt_d   = '0;
                    state_d = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q == settle_last) begin
                    start_val_d = sync_bin;
                    cnt_d       = '0;
                    state_d     = MEASURE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            MEASURE: begin
                if (cnt_q == win_last) begin
                    // Modular difference handles a single counter wrap.
                    result_d = sync_bin - start_val_q;
                    valid_d  = 1'b1;
                    cnt_d    = '0;
                    state_d  = DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                if (lab.result_ack) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        ring_en_d = (state_d == SETTLE) || (state_d == MEASURE);
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            win_q       <= '0;
            set_q       <= '0;
            start_val_q <= '0;
            result_q    <= '0;
            valid_q     <= 1'b0;
            ring_en_q   <= 1'b0;
            sync1_q     <= '0;
            sync2_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            win_q       <= win_d;
            set_q       <= set_d;
            start_val_q <= start_val_d;
            result_q    <= result_d;
            valid_q     <= valid_d;
            ring_en_q   <= ring_en_d;
            sync1_q     <= ring_count_gray;
            sync2_q     <= sync1_q;
        end
    end

    assign ring_en          = ring_en_q;
    assign lab.busy         = (state_q != IDLE);
    assign lab.result       = result_q;
    assign lab.result_valid = valid_q;

endmodule

// File: tb/tb_ring_delay_meter.sv
// ---------------------------------------------------------------------------
// tb_ring_delay_meter
//   Directed bench for ring_delay_meter. A behavioural ring counter advances
//   on the falling clock edge every ring_div cycles (0 = frozen); outputs are
//   sampled 1 time unit after the rising edge.
// ---------------------------------------------------------------------------
module tb_ring_delay_meter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] ring_bin = '0;
    logic [15:0] ring_gray;
    logic        ring_en;
    int          ring_div = 0;
    int          ring_ph  = 0;
    int          n_chk = 0;
    int          n_pass = 0;
    int          lat, en_cnt;

    ring_delay_meter_if #(.CW(16), .WW(16), .SW(8)) lab ();

    ring_delay_meter #(.CW(16), .WW(16), .SW(8)) dut (
        .wb_clk_i        (clk),
        .wb_rst_i        (rst),
        .lab             (lab),
        .ring_count_gray (ring_gray),
        .ring_en         (ring_en)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ring_div != 0) begin
            ring_ph = ring_ph + 1;
            if (ring_ph >= ring_div) begin
                ring_ph  = 0;
                ring_bin = ring_bin + 16'd1;
            end
        end
    end
    assign ring_gray = ring_bin ^ (ring_bin >> 1);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse start (cycle 1 = the cycle start is high) and count cycles until
    // result_valid; poke re-pulses start during SETTLE and MEASURE.
    task automatic run_meas(input int s, input int w, input bit poke,
                            output int l, output int en);
        lab.settle_cycles = 8'(s);
        lab.window_cycles = 16'(w);
        lab.start = 1'b1;
        l  = 0;
        en = 0;
        while (l < 2000) begin
            tick();
            l++;
            lab.start = poke && (l == 3 || l == 20);
            if (ring_en) en++;
            if (lab.result_valid) break;
        end
        lab.start = 1'b0;
        if (l >= 2000) chk("timeout", 32'd0, 32'd1);
    endtask

    initial begin
        lab.start = 1'b0;
        lab.window_cycles = '0;
        lab.settle_cycles = '0;
        lab.result_ack = 1'b0;

        // 1: reset
        repeat (3) tick();
        chk("rst_ring_en", 32'(ring_en), 0);
        chk("rst_busy", 32'(lab.busy), 0);
        chk("rst_result", 32'(lab.result), 0);
        chk("rst_valid", 32'(lab.result_valid), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", 32'(lab.busy), 0);

        // 2: ring ticks every 2 cycles, settle 4, window 100
        ring_bin = 16'd0; ring_div = 2;
        run_meas(4, 100, 1'b0, lat, en_cnt);
        chk("t2_latency", 32'(lat), 107);
        chk("t2_result", 32'(lab.result), 50);
        chk("t2_ring_en_cycles", 32'(en_cnt), 106);
        chk("t2_busy_done", 32'(lab.busy), 1);
        lab.result_ack = 1'b1; tick();
        // ack stays high across into IDLE: must be harmless
        tick(); lab.result_ack = 1'b0;
        chk("t2_valid_cleared", 32'(lab.result_valid), 0);
        chk("t2_result_held", 32'(lab.result), 50);
        chk("t2_busy_idle", 32'(lab.busy), 0);

        // 3: wrap through 0x0000
        ring_div = 0; ring_bin = 16'hFFF0; ring_div = 1; ring_ph = 0;
        run_meas(0, 32, 1'b0, lat, en_cnt);
        chk("t3_latency", 32'(lat), 35);
        chk("t3_result_wrap", 32'(lab.result), 32);
        lab.result_ack = 1'b1; tick(); lab.result_ack = 1'b0;

        // 4: zero window, frozen counter
        ring_div = 0; ring_bin = 16'h1234;
        repeat (3) tick();
        run_meas(0, 0, 1'b0, lat, en_cnt);
        chk("t4_latency", 32'(lat), 4);
        chk("t4_result", 32'(lab.result), 0);
        lab.result_ack = 1'b1; tick(); lab.result_ack = 1'b0;

        // 5: start pulses in SETTLE/MEASURE/DONE ignored
        ring_bin = 16'd0; ring_div = 2; ring_ph = 0;
        run_meas(4, 30, 1'b1, lat, en_cnt);
        chk("t5_latency", 32'(lat), 37);
        chk("t5_result", 32'(lab.result), 15);
        lab.start = 1'b1; tick(); lab.start = 1'b0;
        chk("t5_done_start_busy", 32'(lab.busy), 1);
        chk("t5_done_start_valid", 32'(lab.result_valid), 1);
        chk("t5_done_start_ring", 32'(ring_en), 0);
        lab.result_ack = 1'b1; tick(); lab.result_ack = 1'b0;
        repeat (5) tick();
        chk("t5_no_second_run", 32'(lab.busy), 0);
        run_meas(0, 5, 1'b0, lat, en_cnt);
        chk("t5b_latency", 32'(lat), 8);
        lab.start = 1'b1; lab.result_ack = 1'b1; tick();
        lab.start = 1'b0; lab.result_ack = 1'b0;
        chk("t5b_ack_valid", 32'(lab.result_valid), 0);
        chk("t5b_ack_busy", 32'(lab.busy), 0);
        tick();
        chk("t5b_start_dropped", 32'(lab.busy), 0);

        // 6: reset in MEASURE cycle 10, then a fresh run
        lab.settle_cycles = 8'd4; lab.window_cycles = 16'd100;
        lab.start = 1'b1; tick(); lab.start = 1'b0;
        repeat (14) tick();
        chk("t6_busy_measure", 32'(ring_en), 1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("t6_rst_busy", 32'(lab.busy), 0);
        chk("t6_rst_ring_en", 32'(ring_en), 0);
        chk("t6_rst_valid", 32'(lab.result_valid), 0);
        chk("t6_rst_result", 32'(lab.result), 0);
        tick();
        ring_bin = 16'h0100; ring_ph = 0;
        run_meas(4, 100, 1'b0, lat, en_cnt);
        chk("t6_latency", 32'(lat), 107);
        chk("t6_result", 32'(lab.result), 50);
        lab.result_ack = 1'b1; tick(); lab.result_ack = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ring_delay_meter.md
Name: ring_delay_meter

Overview:
- Sits directly downstream of the instrumented adder wrapper and consumes its ring-oscillator tick counter.
- The ring counter runs in the ring clock domain and is presented Gray-coded.
- This block enables the ring and synchronises the counter into wb_clk_i. It then measures ticks over a programmable window of wb_clk_i cycles and returns the tick count to the logic-analyser registers through a valid/ack handshake.
- Firmware derives adder path delay from the tick count and the window length.

Parameters:
- CW, 16, width of the ring tick counter and of result.
- WW, 16, width of window_cycles.
- SW, 8, width of settle_cycles.

Ports:
- wb_clk_i  input  1  system clock; all logic runs on its rising edge.
- wb_rst_i  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle request to begin a measurement; sampled only in IDLE.
- window_cycles  input  WW  measurement window length in wb_clk_i cycles; latched at start.
- settle_cycles  input  SW  ring warm-up time before the window opens; latched at start.
- ring_count_gray  input  CW  Gray-coded ring tick counter, asynchronous to wb_clk_i.
- ring_en  output  1  enable to the ring oscillator.
- busy  output  1  high in every state except IDLE.
- result  output  CW  ticks counted during the window, modulo 2^CW.
- result_valid  output  1  result is held stable while this is high.
- result_ack  input  1  consumer acknowledge; sampled only in DONE.

Behaviour:
- Reset (wb_rst_i high at a rising edge):
  - FSM goes to IDLE.
  - ring_en=0, busy=0, result=0, result_valid=0.
  - Synchroniser flops and internal counters clear to 0.
  - Reset asserted mid-measurement aborts immediately, with no result produced.
- Synchroniser: ring_count_gray passes through 2 flops, then is Gray-to-binary converted combinationally. This gives sync_bin, which lags the input by 2 cycles.
- FSM states: IDLE, SETTLE, MEASURE, DONE.
- IDLE:
  - start=1 latches window_cycles and settle_cycles.
  - A latched window of 0 is treated as 1.
  - Next state is SETTLE and ring_en goes to 1 on the same edge.
- SETTLE:
  - Counter runs for settle_cycles+2 cycles; the +2 covers synchroniser latency.
  - On the final cycle, sync_bin is captured as start_val and the FSM moves to MEASURE.
  - start is ignored.
- MEASURE:
  - Counter runs for the latched window cycles.
  - On the final cycle, sync_bin is captured as end_val.
  - On that same edge: result = end_val - start_val (unsigned, modulo 2^CW), result_valid=1, ring_en=0, next state DONE.
- DONE:
  - result_ack=1 clears result_valid and moves to IDLE.
  - result keeps its value until the next capture.
  - start is ignored in DONE.
  - An ack held across DONE→IDLE has no effect in IDLE.
- Latency from start to result_valid is exactly 1 + (settle_cycles+2) + max(window_cycles,1) cycles.
- busy = (state != IDLE).
- ring_en is high exactly in SETTLE and MEASURE.
- Wrap-around: if the ring counter wraps more than once within the window, the result aliases. Firmware keeps ring_freq × window below 2^CW. No overflow flag is provided.
- Simultaneous start and result_ack in DONE: the ack is honoured and the start is dropped.
- Inputs change only between measurements; values latched at start govern the measurement in flight.

Test Plan:
1. Reset with wb_rst_i=1 for 3 cycles -> ring_en=0, busy=0, result=0, result_valid=0.
2. Bench ring counter increments every 2 wb_clk cycles (Gray-coded); settle=4, window=100, start pulse -> result_valid rises exactly 107 cycles after the start edge, result=50, ring_en high for exactly 106 cycles.
3. Ring counter starts at 0xFFF0 and increments by 1 every cycle; window=32 -> result=32, checking modulo wrap through 0x0000.
4. window_cycles=0, settle=0, counter frozen at 0x1234 -> result_valid rises 4 cycles after start, result=0.
5. Pulse start during SETTLE, MEASURE and DONE -> no restart and no second measurement. In DONE, start and result_ack together -> IDLE, result_valid=0, busy=0.
6. Assert wb_rst_i in MEASURE cycle 10 -> next edge: IDLE, ring_en=0, result_valid=0. A fresh start afterwards completes with the correct count.
